// File: rtl/dbus_lsu_pkg.sv
// dbus_lsu_pkg: shared data-bus transfer types
package dbus_lsu_pkg;
    typedef enum logic {READ, WRITE} ttype_t;
    typedef enum logic [1:0] {BYTE, HALFWORD, WORD} tsize_t;
endpackage

// File: rtl/slave_bus_if.sv
// slave_bus_if: word-wide data bus between a master and the on-chip RAM
interface slave_bus_if;
    import dbus_lsu_pkg::*;
    logic        ss;
    logic [31:0] addr;
    ttype_t      ttype;
    tsize_t      tsize;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    modport master (output ss, addr, ttype, tsize, wdata, input rdata, bdone);
    modport slave (input ss, addr, ttype, tsize, wdata, output rdata, bdone);
endinterface

// File: rtl/dbus_lsu_lane.sv
// lsu_lane: sub-word lane extract/extend for loads and lane merge for stores
module lsu_lane
    import dbus_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  tsize_t      size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        load_data = size == BYTE ? {{24{~is_unsigned & b[7]}}, b}
                  : size == HALFWORD ? {{16{~is_unsigned & h[15]}}, h} : word;
        merged_word = size == WORD ? wdata : word;
        if (size == BYTE)
            merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
        else if (size == HALFWORD)
            merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/dbus_lsu.sv
// dbus_lsu: single-outstanding load/store unit issuing aligned word transfers with RMW sub-word stores
module dbus_lsu
    import dbus_lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  tsize_t      req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    slave_bus_if.master dbus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);
    state_t      state, state_nx;
    tsize_t      size_q;
    logic        store_q, uns_q, err_q, misaligned, accept;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, wr_q, rdata_q, load_data, merged_word;

    lsu_lane u_lane (
        .word       (dbus.rdata),
        .addr       (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merged_word(merged_word)
    );

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_size == HALFWORD && req_addr[0]) || (req_size == WORD && req_addr[1:0] != 2'b00);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = misaligned ? RESP : (req_store && req_size == WORD) ? WR : RD;
            RD:      if (dbus.bdone) state_nx = WAIT;
            WAIT:    if (cnt_q == 2'd0) state_nx = store_q ? WR : RESP;
            WR:      if (dbus.bdone) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready   = state == IDLE;
    assign resp_valid  = state == RESP;
    assign resp_rdata  = resp_valid ? rdata_q : '0;
    assign resp_error  = resp_valid && err_q;
    assign dbus.ss     = state == RD || state == WR;
    assign dbus.addr   = dbus.ss ? {addr_q[31:2], 2'b00} : '0;
    assign dbus.ttype  = state == WR ? WRITE : READ;
    assign dbus.tsize  = WORD;
    assign dbus.wdata  = state == WR ? wr_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            size_q  <= WORD;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                size_q  <= req_size;
                store_q <= req_store;
                uns_q   <= req_unsigned;
                err_q   <= misaligned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_wdata;
                rdata_q <= '0;
            end
            if (state == RD)
                cnt_q <= LAT_INIT;
            if (state == WAIT) begin
                cnt_q <= cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    rdata_q <= store_q ? '0 : load_data;
                    wr_q    <= merged_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_dbus_lsu.sv
// tb_dbus_lsu: directed and randomized checks of dbus_lsu against a behavioural RAM/LSU model
module tb_dbus_lsu;
    import dbus_lsu_pkg::*;
    localparam int RL = 2;
    typedef struct packed {logic wr; logic word; logic [31:0] addr; logic [31:0] wdata;} op_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
    tsize_t      req_size = WORD;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem [0:63];
    logic [31:0] rd_word;
    int          rd_cnt = 0, stall_rd = 0, stall_wr = 0;
    bit          rand_bd = 1'b0;
    int          checks = 0, passed = 0;
    op_t         log_q[$];

    slave_bus_if bus();

    dbus_lsu #(.READ_LATENCY(RL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .dbus        (bus)
    );

    always #5 clk = ~clk;

    // bdone changes mid-cycle; forced stalls take priority over random/always-ready behaviour
    always @(negedge clk) begin
        if (bus.ss && bus.ttype == READ && stall_rd > 0) begin
            bus.bdone = 1'b0;
            stall_rd--;
        end else if (bus.ss && bus.ttype == WRITE && stall_wr > 0) begin
            bus.bdone = 1'b0;
            stall_wr--;
        end else
            bus.bdone = rand_bd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // RAM: rdata is garbage until READ_LATENCY edges after the read handshake
    always @(posedge clk) begin
        if (rd_cnt == 1) bus.rdata <= rd_word;
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (bus.ss && bus.bdone) begin
            log_q.push_back(op_t'{bus.ttype == WRITE, bus.tsize == WORD, bus.addr, bus.wdata});
            if (bus.ttype == WRITE)
                mem[bus.addr[7:2]] = bus.wdata;
            else begin
                rd_word   <= mem[bus.addr[7:2]];
                rd_cnt    <= RL - 1;
                bus.rdata <= (RL == 1) ? mem[bus.addr[7:2]] : $urandom;
            end
        end
    end

    function automatic void ref_op(input logic st, input tsize_t sz, input logic uns, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] mw,
                                   output logic err, output logic [31:0] rd, output logic [31:0] nw);
        int sh;
        logic [31:0] mask, v;
        sh = 8 * int'(a[1:0]);
        mask = sz == BYTE ? 32'hFF : sz == HALFWORD ? 32'hFFFF : 32'hFFFF_FFFF;
        err = (sz == HALFWORD && a % 2 != 0) || (sz == WORD && a % 4 != 0);
        rd = '0;
        nw = mw;
        if (err) return;
        v = (mw >> sh) & mask;
        if (!st) rd = (!uns && sz != WORD && v > (mask >> 1)) ? (v | ~mask) : v;
        else nw = (mw & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic do_req(input logic st, input tsize_t sz, input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err, output logic rdy_after,
                          output int bad, output int rc, output int wc);
        req_valid = 1'b1;
        req_store = st;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = ~st;
        req_unsigned = ~uns;
        req_addr = $urandom;
        req_wdata = $urandom;
        lat = 0;
        bad = 0;
        rc = 0;
        wc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.ss === 1'b1) begin
                if (bus.ttype == READ) rc++; else wc++;
                if (bus.addr !== {a[31:2], 2'b00} || bus.tsize !== WORD || (bus.ttype == READ && bus.wdata !== 32'h0)) bad++;
            end else if (bus.addr !== 32'h0 || bus.wdata !== 32'h0 || bus.ttype !== READ || bus.tsize !== WORD) bad++;
        end while (resp_valid !== 1'b1 && lat < 200);
        rd = resp_rdata;
        err = resp_error;
        @(negedge clk);
        rdy_after = req_ready === 1'b1 && resp_valid === 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
        checks++; if ({resp_valid, resp_error, resp_rdata} !== 34'h0) $display("FAIL reset_resp got %b/%b/%h want 0/0/0", resp_valid, resp_error, resp_rdata); else passed++;
        checks++; if ({bus.ss, bus.addr, bus.wdata} !== 65'h0) $display("FAIL reset_bus got ss=%b addr=%h wdata=%h want 0", bus.ss, bus.addr, bus.wdata); else passed++;
        checks++; if (bus.ttype !== READ || bus.tsize !== WORD) $display("FAIL reset_type got %0d/%0d want READ/WORD", bus.ttype, bus.tsize); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int lat, bad, rc, wc;
        logic [31:0] rd;
        logic err, rdy;
        logic [31:0] ta [3] = '{32'h13, 32'h13, 32'h12};
        tsize_t      ts [3] = '{BYTE, BYTE, HALFWORD};
        logic        tu [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] te [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        mem[4] = 32'hDEAD_BEEF;
        log_q.delete();
        do_req(1'b0, WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 2 + RL) $display("FAIL load_latency got %0d want %0d", lat, 2 + RL); else passed++;
        checks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) $display("FAIL load_word got %h/%b want deadbeef/0", rd, err); else passed++;
        checks++; if (log_q.size() != 1 || log_q[0] !== op_t'{1'b0, 1'b1, 32'h10, 32'h0}) $display("FAIL load_bus got %0d ops want one READ WORD @10", log_q.size()); else passed++;
        checks++; if (rdy !== 1'b1 || bad !== 0) $display("FAIL load_handshake got ready=%b bad=%0d want 1/0", rdy, bad); else passed++;
        mem[4] = 32'h80FF_1234;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, ts[i], tu[i], ta[i], 32'h0, lat, rd, err, rdy, bad, rc, wc);
            checks++; if (rd !== te[i] || err !== 1'b0) $display("FAIL subword_load%0d got %h/%b want %h/0", i, rd, err, te[i]); else passed++;
        end
    endtask

    task automatic test_store();
        int lat, bad, rc, wc;
        logic [31:0] rd;
        logic err, rdy;
        mem[8] = 32'h1122_3344;
        log_q.delete();
        do_req(1'b1, BYTE, 1'b0, 32'h21, 32'h0000_00AB, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 3 + RL) $display("FAIL byte_store_latency got %0d want %0d", lat, 3 + RL); else passed++;
        checks++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL byte_store_resp got %h/%b want 0/0", rd, err); else passed++;
        checks++; if (log_q.size() != 2 || log_q[0] !== op_t'{1'b0, 1'b1, 32'h20, 32'h0} || log_q[1] !== op_t'{1'b1, 1'b1, 32'h20, 32'h1122_AB44})
            $display("FAIL byte_store_bus got %0d ops want READ then WRITE 1122ab44 @20", log_q.size()); else passed++;
        do_req(1'b0, WORD, 1'b0, 32'h20, 32'h0, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (rd !== 32'h1122_AB44) $display("FAIL byte_store_readback got %h want 1122ab44", rd); else passed++;
        do_req(1'b1, HALFWORD, 1'b0, 32'h22, 32'h5555_CAFE, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (mem[8] !== 32'hCAFE_AB44 || bad !== 0) $display("FAIL half_store got %h bad=%0d want cafeab44 0", mem[8], bad); else passed++;
        log_q.delete();
        do_req(1'b1, WORD, 1'b0, 32'h24, 32'h0123_4567, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 2) $display("FAIL word_store_latency got %0d want 2", lat); else passed++;
        checks++; if (log_q.size() != 1 || log_q[0] !== op_t'{1'b1, 1'b1, 32'h24, 32'h0123_4567} || mem[9] !== 32'h0123_4567)
            $display("FAIL word_store_bus got %0d ops mem=%h want one WRITE 01234567", log_q.size(), mem[9]); else passed++;
    endtask

    task automatic test_misaligned();
        int lat, bad, rc, wc;
        logic [31:0] rd;
        logic err, rdy;
        logic        ts_st [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tsize_t      ts    [4] = '{HALFWORD, WORD, HALFWORD, WORD};
        logic [31:0] ta    [4] = '{32'h03, 32'h06, 32'h01, 32'h02};
        mem[0] = 32'h0BAD_F00D;
        mem[1] = 32'h600D_CAFE;
        for (int i = 0; i < 4; i++) begin
            log_q.delete();
            do_req(ts_st[i], ts[i], 1'b0, ta[i], 32'hFFFF_FFFF, lat, rd, err, rdy, bad, rc, wc);
            checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned%0d got lat=%0d err=%b rd=%h want 1/1/0", i, lat, err, rd); else passed++;
            checks++; if (rc + wc != 0 || log_q.size() != 0 || mem[0] !== 32'h0BAD_F00D || mem[1] !== 32'h600D_CAFE)
                $display("FAIL misaligned%0d_bus got ss_cycles=%0d ops=%0d want 0/0", i, rc + wc, log_q.size()); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bad, rc, wc;
        logic [31:0] rd;
        logic err, rdy;
        mem[16] = 32'hA5A5_0001;
        mem[17] = 32'h5A5A_0002;
        do_req(1'b0, WORD, 1'b0, 32'h40, 32'h0, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (rdy !== 1'b1 || rd !== 32'hA5A5_0001) $display("FAIL b2b_first got ready=%b rd=%h want 1/a5a50001", rdy, rd); else passed++;
        do_req(1'b0, WORD, 1'b0, 32'h44, 32'h0, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 2 + RL || rd !== 32'h5A5A_0002) $display("FAIL b2b_second got lat=%0d rd=%h want %0d/5a5a0002", lat, rd, 2 + RL); else passed++;
    endtask

    task automatic test_stall();
        int lat, bad, rc, wc;
        logic [31:0] rd;
        logic err, rdy;
        mem[4] = 32'hDEAD_BEEF;
        stall_rd = 3;
        do_req(1'b0, WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 2 + RL + 3 || rc !== 4) $display("FAIL stall_rd_latency got lat=%0d rd_cycles=%0d want %0d/4", lat, rc, 2 + RL + 3); else passed++;
        checks++; if (rd !== 32'hDEAD_BEEF || bad !== 0) $display("FAIL stall_rd_data got %h bad=%0d want deadbeef/0", rd, bad); else passed++;
        stall_wr = 2;
        do_req(1'b1, BYTE, 1'b0, 32'h10, 32'h0000_00EE, lat, rd, err, rdy, bad, rc, wc);
        checks++; if (lat !== 3 + RL + 2 || wc !== 3 || bad !== 0) $display("FAIL stall_wr got lat=%0d wr_cycles=%0d bad=%0d want %0d/3/0", lat, wc, bad, 3 + RL + 2); else passed++;
        checks++; if (mem[4] !== 32'hDEAD_BEEE) $display("FAIL stall_wr_mem got %h want deadbeee", mem[4]); else passed++;
    endtask

    task automatic test_reset_mid_wr();
        int n;
        bit seen;
        mem[12] = 32'hCAFE_F00D;
        log_q.delete();
        stall_wr = 1000;
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size = BYTE;
        req_addr = 32'h31;
        req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!(bus.ss === 1'b1 && bus.ttype == WRITE) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 50) $display("FAIL rst_wr_reach got %0d cycles want WR within 50", n); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ss !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rst_wr_abort got ss=%b ready=%b valid=%b want 0/1/0", bus.ss, req_ready, resp_valid); else passed++;
        stall_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus.ss !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL rst_wr_quiet got activity=%b want 0", seen); else passed++;
        checks++; if (mem[12] !== 32'hCAFE_F00D || log_q.size() != 1 || log_q[0].wr !== 1'b0) $display("FAIL rst_wr_mem got %h ops=%0d want cafef00d one read", mem[12], log_q.size()); else passed++;
    endtask

    task automatic test_random();
        int lat, bad, rc, wc, exp_lat;
        logic [31:0] rd, a, wd, exp_rd, exp_nw, old_w;
        logic err, rdy, st, uns, exp_err;
        tsize_t sz;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rand_bd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz = tsize_t'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 255));
            wd = $urandom;
            old_w = mem[a[7:2]];
            ref_op(st, sz, uns, a, wd, old_w, exp_err, exp_rd, exp_nw);
            do_req(st, sz, uns, a, wd, lat, rd, err, rdy, bad, rc, wc);
            exp_lat = exp_err ? 1 : rc + wc + (rc > 0 ? RL : 0) + 1;
            checks++; if (rd !== exp_rd || err !== exp_err) $display("FAIL rand%0d_resp got %h/%b want %h/%b", i, rd, err, exp_rd, exp_err); else passed++;
            checks++; if (mem[a[7:2]] !== exp_nw) $display("FAIL rand%0d_mem got %h want %h", i, mem[a[7:2]], exp_nw); else passed++;
            checks++; if ((rc > 0) !== (!exp_err && (!st || sz != WORD)) || (wc > 0) !== (!exp_err && st) || bad !== 0)
                $display("FAIL rand%0d_bus got rd_cycles=%0d wr_cycles=%0d bad=%0d", i, rc, wc, bad); else passed++;
            checks++; if (lat !== exp_lat || rdy !== 1'b1) $display("FAIL rand%0d_timing got lat=%0d ready=%b want %0d/1", i, lat, rdy, exp_lat); else passed++;
        end
        rand_bd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_stall();
        test_reset_mid_wr();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
